// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_pkg
//  Description : Shared encodings and defaults for the microprogram sequencer
//                (next-state select, condition select, reset state).
//  Revision    : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

   // Default width of a microstate number
   localparam int STATE_W_DEFAULT = 7;

   // State entered on reset, timeout recovery and illegal ns_sel
   localparam int RESET_STATE = 0;

   // Next-state select field of a microinstruction
   typedef enum logic [2:0] {
      NS_FETCH  = 3'b000,  // jump to decoder-supplied first microstate
      NS_INC    = 3'b001,  // fall through to current_state + 1
      NS_COND   = 3'b010,  // cond ? cr : inc
      NS_JUMP   = 3'b011,  // unconditional jump to cr
      NS_CALL   = 3'b100,  // jump to cr, remember inc as return point
      NS_RETURN = 3'b101,  // jump to remembered return point
      NS_RSVD6  = 3'b110,  // reserved, flagged as illegal
      NS_RSVD7  = 3'b111   // reserved, flagged as illegal
   } ns_sel_e;

   // Condition select field of a microinstruction
   typedef enum logic [2:0] {
      CS_MOC      = 3'b000,
      CS_ZERO     = 3'b001,
      CS_NEGATIVE = 3'b010,
      CS_CARRY    = 3'b011,
      CS_OVERFLOW = 3'b100,
      CS_ONE      = 3'b101,
      CS_ZERO6    = 3'b110,
      CS_ZERO7    = 3'b111
   } cond_sel_e;

endpackage : control_sequencer_pkg
`default_nettype wire

// File: rtl/control_sequencer_cond_mux.sv
`default_nettype none
// ============================================================================
//  Module      : cond_mux
//  Description : Selects one branch condition from the memory/ALU flags and
//                optionally inverts it. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_mux
   import control_sequencer_pkg::*;
(
   input  logic [2:0] cond_sel,
   input  logic       inv,
   input  logic       moc,
   input  logic       zero,
   input  logic       negative,
   input  logic       carry,
   input  logic       overflow,
   output logic       cond
);

   logic w_selected;

   // Pick the flag named by cond_sel; unused encodings read as constant 0
   always_comb begin
      w_selected = 1'b0;
      case (cond_sel)
         CS_MOC:      w_selected = moc;
         CS_ZERO:     w_selected = zero;
         CS_NEGATIVE: w_selected = negative;
         CS_CARRY:    w_selected = carry;
         CS_OVERFLOW: w_selected = overflow;
         CS_ONE:      w_selected = 1'b1;
         default:     w_selected = 1'b0;
      endcase
   end

   assign cond = w_selected ^ inv;

endmodule : cond_mux
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Microprogram sequencer. Computes the next microstore address
//                from the current microinstruction, with a single-level
//                call/return register and a self-loop watchdog that forces a
//                return to state 0 when a wait loop never exits.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int STATE_W        = STATE_W_DEFAULT,
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [STATE_W-1:0] encoded_state,
   input  logic [2:0]         ns_sel,
   input  logic [2:0]         cond_sel,
   input  logic               inv,
   input  logic [STATE_W-1:0] cr,
   input  logic               moc,
   input  logic               zero,
   input  logic               negative,
   input  logic               carry,
   input  logic               overflow,
   input  logic               hold,
   output logic [STATE_W-1:0] current_state,
   output logic               timeout,
   output logic               illegal
);

   // Counter must be able to represent its saturation value TIMEOUT_CYCLES
   localparam int                 CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]   C_CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]   C_CNT_TRIP = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [STATE_W-1:0] C_RESET_ST = STATE_W'(RESET_STATE);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] r_ret;
   logic [CNT_W-1:0]   r_loop_cnt;
   logic               r_timeout;
   logic               r_illegal;

   logic               w_cond;
   logic [STATE_W-1:0] w_inc;
   logic [STATE_W-1:0] w_decoded;
   logic               w_call;
   logic               w_illegal_sel;
   logic               w_self_loop;
   logic               w_recover;
   logic [STATE_W-1:0] w_next_state;
   logic [CNT_W-1:0]   w_next_cnt;
   logic               w_next_timeout;
   logic               w_next_illegal;

   cond_mux u_cond_mux (
      .cond_sel (cond_sel),
      .inv      (inv),
      .moc      (moc),
      .zero     (zero),
      .negative (negative),
      .carry    (carry),
      .overflow (overflow),
      .cond     (w_cond)
   );

   // Natural wrap from the top state back to 0
   assign w_inc = r_state + STATE_W'(1);

   // Decode ns_sel into the candidate next state before watchdog override
   always_comb begin
      w_decoded     = r_state;
      w_call        = 1'b0;
      w_illegal_sel = 1'b0;
      case (ns_sel)
         NS_FETCH:  w_decoded = encoded_state;
         NS_INC:    w_decoded = w_inc;
         NS_COND:   w_decoded = w_cond ? cr : w_inc;
         NS_JUMP:   w_decoded = cr;
         NS_CALL: begin
            w_decoded = cr;
            w_call    = 1'b1;
         end
         NS_RETURN: w_decoded = r_ret;
         default: begin
            w_decoded     = C_RESET_ST;
            w_illegal_sel = 1'b1;
         end
      endcase
   end

   // Watchdog: a self-loop arriving with the counter one short of the limit
   // becomes a forced jump to state 0 and suppresses the illegal pulse
   always_comb begin
      w_self_loop    = (w_decoded == r_state);
      w_recover      = w_self_loop && (r_loop_cnt == C_CNT_TRIP);
      w_next_state   = w_recover ? C_RESET_ST : w_decoded;
      w_next_timeout = w_recover;
      w_next_illegal = w_illegal_sel && !w_recover;
      if (w_recover || !w_self_loop) begin
         w_next_cnt = '0;
      end else if (r_loop_cnt == C_CNT_MAX) begin
         w_next_cnt = r_loop_cnt;
      end else begin
         w_next_cnt = r_loop_cnt + CNT_W'(1);
      end
   end

   // State register: reset wins over hold; hold freezes state and clears pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= C_RESET_ST;
         r_ret      <= C_RESET_ST;
         r_loop_cnt <= '0;
         r_timeout  <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (hold) begin
         r_timeout  <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_loop_cnt <= w_next_cnt;
         r_timeout  <= w_next_timeout;
         r_illegal  <= w_next_illegal;
         // A call overridden by watchdog recovery does not take effect
         if (w_call && !w_recover) begin
            r_ret <= w_inc;
         end
      end
   end

   // Outputs come straight from registers
   always_comb begin
      current_state = r_state;
      timeout       = r_timeout;
      illegal       = r_illegal;
   end

endmodule : control_sequencer
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters SHALL be: STATE_W, 7, state-number width; TIMEOUT_CYCLES, 16, max consecutive self-loop cycles before forced recovery.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 encoded_state  input  STATE_W  first microstate of the current instruction, from the instruction decoder.
REQ-005 ns_sel  input  3  next-state select field of the current microinstruction.
REQ-006 cond_sel  input  3  condition select field of the current microinstruction.
REQ-007 inv  input  1  inverts the selected condition.
REQ-008 cr  input  STATE_W  target state field of the current microinstruction.
REQ-009 moc, zero, negative, carry, overflow  input  1 each  memory-operation-complete and ALU flags.
REQ-010 hold  input  1  external stall; freezes the sequencer.
REQ-011 current_state  output  STATE_W  registered state number driving the microstore address.
REQ-012 timeout  output  1  one-cycle pulse on forced timeout recovery.
REQ-013 illegal  output  1  one-cycle pulse on a reserved ns_sel encoding.

Function
REQ-014 cond SHALL be the cond_sel-selected signal XOR inv: 000 moc, 001 zero, 010 negative, 011 carry, 100 overflow, 101 constant 1, 110/111 constant 0.
REQ-015 inc SHALL be current_state+1 modulo 2^STATE_W (127 wraps to 0).
REQ-016 next state by ns_sel: 000 encoded_state; 001 inc; 010 cond ? cr : inc; 011 cr; 100 call (cr, ret_reg<=inc); 101 return (ret_reg); 110/111 state 0 with illegal pulse.
REQ-017 ret_reg SHALL be a single STATE_W register, written only by a call; a return without a prior call yields the reset value 0.
REQ-018 A call whose cr equals current_state SHALL still write ret_reg.
REQ-019 Each rising edge with hold=0 and reset=0 SHALL load the computed next state into current_state; latency from inputs to current_state is one cycle.
REQ-020 With hold=1, current_state, ret_reg, the self-loop counter and all outputs SHALL hold; timeout/illegal SHALL be 0 during hold.
REQ-021 Self-loop counter SHALL increment on each non-held edge where next state equals current_state, saturating at TIMEOUT_CYCLES, and clear on any edge where the state changes.
REQ-022 When the counter equals TIMEOUT_CYCLES-1 and another self-loop is computed, next state SHALL be 0, timeout SHALL pulse one cycle, and the counter SHALL clear.
REQ-023 Priority per edge: reset > hold > timeout recovery > illegal > ns_sel decode.
REQ-024 timeout and illegal SHALL be registered and never assert in the same cycle.

Reset
REQ-025 reset=1 at a rising edge SHALL set current_state=0, ret_reg=0, counter=0, timeout=0, illegal=0, regardless of hold or any other input.
REQ-026 Reset asserted mid-call or mid-wait SHALL discard ret_reg and counter contents; the first post-reset state is 0.

Structure
REQ-027 A shared package SHALL hold ns_sel and cond_sel encodings, RESET_STATE=0 and the STATE_W default.
REQ-028 Condition selection SHALL be a separate combinational sub-module named cond_mux; the remaining logic resides in control_sequencer.

Verification
REQ-029 Fetch/decode: reset, then ns_sel=001 twice, then 000 with encoded_state=10 -> current_state 0,1,2,10.
REQ-030 Conditional: state 5, ns_sel=010, cond_sel=001, inv=0, zero=1, cr=20 -> 20; same with zero=0 -> 6; inv=1, zero=0 -> 20.
REQ-031 Call/return: state 30, ns_sel=100, cr=50 -> 50; then ns_sel=101 -> 31; wrap check: state 127, ns_sel=001 -> 0.
REQ-032 MOC wait: state 7, ns_sel=010, cond_sel=000, inv=1, cr=7, moc=0 -> holds 7 for 15 edges, 16th edge -> state 0 with timeout=1 one cycle; moc=1 at edge 4 -> state 8, no timeout.
REQ-033 Hold/illegal: hold=1 for 3 edges at state 12 -> stays 12; ns_sel=110 -> state 0, illegal=1 one cycle.
REQ-034 Reset mid-operation: reset with hold=1 at state 40 after call -> state 0; ns_sel=101 next -> state 0.
